// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared coin FSM state enum, coin codes and stable-counter width.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    EMIT,
    WAIT_REL
  } coin_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

  // Wide enough for DEB_CYCLES up to 15.
  localparam int STAB_W = 4;

endpackage

// File: rtl/debounce_ctr.sv
// rtl/debounce_ctr.sv - two-flop synchroniser, stable-cycle debounce and registered rising-edge pulse.
module debounce_ctr
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [STAB_W-1:0] DEB_M1 = STAB_W'(DEB_CYCLES - 1);

  logic              s1;
  logic              s2;
  logic              level;
  logic [STAB_W-1:0] cnt;

  // level only follows s2 after DEB_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_M1) begin
        cnt   <= '0;
        level <= s2;
        rise  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_conditioner.sv
// rtl/coin_conditioner.sv - coin/start input conditioner; COIN_LOCKOUT_EN adds LOCK input and REJ output.
module coin_conditioner
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       COIN_RAW,
  input  logic             ST_RAW,
  output logic [1:0]       CN,
  output logic             ST,
  output logic [CNT_W-1:0] COIN_CNT
`ifdef COIN_LOCKOUT_EN
  ,
  input  logic             LOCK,
  output logic             REJ
`endif
);

  localparam logic [STAB_W-1:0] DEB_M1 = STAB_W'(DEB_CYCLES - 1);
  localparam logic [STAB_W-1:0] ONE    = STAB_W'(1);

  logic [1:0]        c1;
  logic [1:0]        code;
  coin_state_t       state;
  coin_state_t       state_n;
  logic [1:0]        cand;
  logic [1:0]        cand_n;
  logic [STAB_W-1:0] cnt;
  logic [STAB_W-1:0] cnt_n;
  logic              emit_go;
  logic              lock;

`ifdef COIN_LOCKOUT_EN
  assign lock = LOCK;
`else
  assign lock = 1'b0;
`endif

  debounce_ctr #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk  (CLK),
    .rst  (RST),
    .raw  (ST_RAW),
    .rise (ST)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c1    <= COIN_NONE;
      code  <= COIN_NONE;
      state <= IDLE;
      cand  <= COIN_NONE;
      cnt   <= '0;
    end else begin
      c1    <= COIN_RAW;
      code  <= c1;
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (code != COIN_NONE) begin
          state_n = QUAL;
          cand_n  = code;
          cnt_n   = ONE;
        end
      end
      QUAL: begin
        if (code == COIN_NONE) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (code != cand) begin
          cand_n = code;
          cnt_n  = ONE;
        end else if (cnt == DEB_M1) begin
          state_n = EMIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      EMIT: begin
        state_n = WAIT_REL;
        cnt_n   = '0;
      end
      WAIT_REL: begin
        // Any nonzero sample restarts the release count, so bounce cannot re-trigger.
        if (code != COIN_NONE) begin
          cnt_n = '0;
        end else if (cnt == DEB_M1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign emit_go = (state == QUAL) && (state_n == EMIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CN       <= COIN_NONE;
      COIN_CNT <= '0;
    end else begin
      CN <= (emit_go && !lock) ? cand : COIN_NONE;
      if (emit_go && !lock && (COIN_CNT != {CNT_W{1'b1}})) begin
        COIN_CNT <= COIN_CNT + 1'b1;
      end
    end
  end

`ifdef COIN_LOCKOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      REJ <= 1'b0;
    end else begin
      REJ <= emit_go && lock;
    end
  end
`endif

endmodule

// File: doc/coin_conditioner.md
COIN_CONDITIONER -- requirements
Module: coin_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, consecutive stable cycles needed to qualify any raw input (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 8, width of the accepted-coin counter.
REQ-003 SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port COIN_RAW  input  2  unsynchronised coin sensor code: 00 none, 01/10/11 denominations.
REQ-006 SHALL have port ST_RAW  input  1  unsynchronised start button, high = pressed.
REQ-007 SHALL have port CN  output  2  qualified coin code to the next-state logic; 00 when no coin event.
REQ-008 SHALL have port ST  output  1  one-cycle start strobe to the next-state logic.
REQ-009 SHALL have port COIN_CNT  output  CNT_W  count of accepted coins.

Function
REQ-010 SHALL pass COIN_RAW and ST_RAW through two-flop synchronisers before any other use; this latency is counted in every figure below.
REQ-011 SHALL run the coin FSM with states IDLE, QUAL, EMIT and WAIT_REL.
REQ-012 IDLE: synchronised code != 00 -> QUAL, load the candidate code, stable counter = 1.
REQ-013 QUAL: code equal to candidate -> counter increments; code different and nonzero -> reload candidate, counter = 1; code = 00 -> IDLE.
REQ-014 QUAL: counter reaching DEB_CYCLES -> EMIT.
REQ-015 EMIT: lasts exactly one cycle; CN = candidate; COIN_CNT increments (saturates at all-ones, no wrap); then -> WAIT_REL.
REQ-016 WAIT_REL: CN = 00; stays until synchronised code = 00 for DEB_CYCLES consecutive cycles, then -> IDLE; a held or bouncing coin never emits twice.
REQ-017 CN SHALL be 00 in every state except EMIT.
REQ-018 ST SHALL pulse high one cycle when debounced ST_RAW goes from 0 to 1; a held button gives one pulse, and re-arming needs DEB_CYCLES stable-low cycles.
REQ-019 ST and a nonzero CN MAY assert in the same cycle; neither is delayed or dropped.
REQ-020 Registered outputs only: CN and ST SHALL come from flops, not be decoded combinationally from raw inputs.

Reset
REQ-021 With RST high, the block SHALL immediately force CN = 00, ST = 0, COIN_CNT = 0, coin FSM = IDLE, counters = 0 and synchroniser flops = 0.
REQ-022 RST asserted mid-QUAL or mid-EMIT SHALL abort the event with no CN emitted; after release, a still-present coin SHALL be requalified from IDLE.

Configuration
REQ-023 Macro COIN_LOCKOUT_EN, when defined, SHALL add input LOCK (1 bit) and output REJ (1 bit, reset 0).
REQ-024 With COIN_LOCKOUT_EN and LOCK high in the cycle the FSM would enter EMIT: CN stays 00, COIN_CNT is unchanged, REJ pulses one cycle, and the FSM still goes through WAIT_REL.
REQ-025 Without COIN_LOCKOUT_EN, the LOCK and REJ ports SHALL be absent and every qualified coin SHALL be emitted.

Structure
REQ-026 Shared package coin_pkg SHALL hold the coin FSM state enum and the coin code constants COIN_NONE = 00, COIN_A = 01, COIN_B = 10 and COIN_C = 11.
REQ-027 Sub-module debounce_ctr (sync + stable counter + rising-edge pulse) SHALL be used for the start path and MAY be reused for the release check.

Verification (DEB_CYCLES = 4)
REQ-028 Bench SHALL cover: COIN_RAW = 10 held 20 cycles -> CN = 10 for exactly one cycle, 2+4 cycles after the input change; COIN_CNT 0 -> 1; no second pulse.
REQ-029 Bench SHALL cover: COIN_RAW toggling 01/00 every 2 cycles for 16 cycles -> CN stays 00 and COIN_CNT stays 0.
REQ-030 Bench SHALL cover: COIN_RAW = 01 held 2 cycles, then 11 held 10 cycles -> a single CN = 11 pulse and no CN = 01.
REQ-031 Bench SHALL cover: ST_RAW high 30 cycles, low 10, high 10 -> exactly two ST pulses.
REQ-032 Bench SHALL cover: RST pulsed during QUAL of coin 01 -> no CN pulse; coin still held after release -> CN = 01 one cycle, 6 cycles after release.
REQ-033 Bench SHALL cover, with COIN_LOCKOUT_EN and LOCK = 1, coin 11 held 10 cycles -> REJ pulses once, CN stays 00, COIN_CNT unchanged.
REQ-034 Bench SHALL cover: CNT_W = 2, 5 valid coins -> COIN_CNT saturates at 3.
